rx_pair_framer: RTL and testbench
=================================

# rx_pair_framer

Input framing stage of the hard-decision Viterbi decoder, directly upstream of the branch-metric units. It collects the demodulated serial hard-decision bit stream into rate-1/2 code-symbol pairs and presents each pair as `rx_pair[1:0]` with a valid/ready handshake. Each pair carries a trellis-step index and frame start/end markers, which the ACS/traceback logic uses to delimit frames.

## Interface
Parameters:
- `FRAME_LEN`, default 64: code-symbol pairs per frame, tail included; legal range 2..2^`SYM_CNT_W`.
- `SYM_CNT_W`, default 8: width of the step index.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low; deassertion is synchronous to `clk` upstream.
- `in_bit` in 1: received hard-decision bit.
- `in_valid` in 1: `in_bit` valid.
- `in_ready` out 1: framer accepts `in_bit` this cycle.
- `flush` in 1: synchronous frame abort and resynchronisation.
- `rx_pair` out 2: symbol pair; `[1]` is the first received bit (G0 output), `[0]` is the second (G1 output).
- `pair_valid` out 1: `rx_pair`, `sym_idx`, `frame_start` and `frame_end` are valid.
- `pair_ready` in 1: downstream consumes the pair.
- `sym_idx` out `SYM_CNT_W`: trellis step of the presented pair, 0..`FRAME_LEN`-1.
- `frame_start` out 1: high when `sym_idx` is 0 (qualified by `pair_valid`).
- `frame_end` out 1: high when `sym_idx` is `FRAME_LEN`-1 (qualified by `pair_valid`).
- `odd_drop` out 1: one-cycle pulse when `flush` discards a held half-pair.

## Operation
- Two-state assembly FSM:
  - EMPTY: no bit held.
  - HALF: first bit held in `hold_bit`.
- EMPTY + accepted bit: the bit goes to `hold_bit`; move to HALF.
- HALF + accepted bit: load `rx_pair` = {`hold_bit`, `in_bit`}; set `pair_valid`; move to EMPTY.
- The output stage is a single register.
  - `in_ready` = !`flush` & (state==EMPTY | !`pair_valid` | `pair_ready`).
  - A first bit is always accepted unless `flush` is high.
  - A second bit is accepted only if the output register is empty or is being drained in the same cycle.
- Output handshake: a transfer occurs when `pair_valid` & `pair_ready`. Without a newly completed pair, `pair_valid` clears on transfer. Drain and load in the same cycle is permitted, giving full throughput of one pair per two input bits.
- Step counter `step_cnt`:
  - It is sampled into `sym_idx` on each pair load and then increments.
  - After `FRAME_LEN`-1 it wraps to 0.
  - `frame_start` and `frame_end` are registered alongside `sym_idx`.
- While `pair_valid` is high and `pair_ready` is low, `rx_pair`, `sym_idx` and the frame flags are held stable.
- `flush` has the highest priority. In its cycle:
  - state goes to EMPTY;
  - `pair_valid` goes to 0 (a pending pair is discarded, not transferred);
  - `step_cnt` goes to 0;
  - `in_ready` is 0, so no input is accepted;
  - `odd_drop` pulses on the next cycle only if state was HALF.
- If `pair_ready` is high in a `flush` cycle, the transfer is not counted: `pair_valid` is already cleared combinationally for downstream. Implementation: `pair_valid` is gated by !`flush`.
- Reset values: state EMPTY; `hold_bit`, `rx_pair`, `sym_idx` and `step_cnt` all 0; `pair_valid`, `frame_start`, `frame_end` and `odd_drop` all 0.
- Asserting `rst_n` mid-pair loses the held bit silently, with no `odd_drop`.

## Timing
- Latency: the second bit of a pair is accepted at edge N, and the pair is valid immediately after edge N (one register stage).
- `in_ready` is combinational from state, `pair_valid`, `pair_ready` and `flush`. All other outputs are registered.
- `odd_drop` is asserted for exactly the one cycle after the `flush` edge.

## Configuration
- `RX_FRAME_CNT_EN` defined:
  - adds output port `frame_cnt` out 16;
  - reset value 0;
  - increments on each output transfer with `frame_end`=1;
  - wraps from 0xFFFF to 0;
  - `flush` does not clear it.
- `RX_FRAME_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then bits 1,0,1,1 with `pair_ready`=1 → pairs 2'b10 then 2'b11; `sym_idx` 0 then 1; `frame_start` set on the first pair only.
- `FRAME_LEN`=4, 10 pairs streamed continuously → `sym_idx` 0,1,2,3,0,1,2,3,0,1; `frame_end` on the 4th and 8th pairs; one pair per 2 cycles, no bubbles.
- `pair_ready`=0 for 5 cycles with a pair pending → `rx_pair` and `sym_idx` stable; the next first bit is accepted; the second bit is stalled (`in_ready`=0) until `pair_ready` rises.
- `flush` while holding one bit → `odd_drop`=1 one cycle later; the next two bits 0,1 produce 2'b01 with `sym_idx`=0.
- `flush` with a pending pair and `pair_ready`=1 → no transfer seen; `pair_valid`=0 the next cycle; the counter restarts at 0.
- With `RX_FRAME_CNT_EN` and `FRAME_LEN`=2: 3 frames → `frame_cnt`=3. `rst_n` pulse mid-frame → all outputs 0 and `frame_cnt`=0.

Source files
------------

// File: rtl/rx_pair_framer.sv
// Rate-1/2 input framer: packs serial hard-decision bits into {G0,G1} pairs with step index and frame markers.
// Optional RX_FRAME_CNT_EN adds a 16-bit count of completed frames handed downstream.
module rx_pair_framer #(
  parameter int FRAME_LEN = 64,
  parameter int SYM_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [1:0]           rx_pair,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic [SYM_CNT_W-1:0] sym_idx,
  output logic                 frame_start,
  output logic                 frame_end,
`ifdef RX_FRAME_CNT_EN
  output logic [15:0]          frame_cnt,
`endif
  output logic                 odd_drop
);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

  localparam logic [SYM_CNT_W-1:0] LAST_IDX = SYM_CNT_W'(FRAME_LEN - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_hold_bit;
  logic [1:0]             r_rx_pair;
  logic                   r_pair_valid;
  logic [SYM_CNT_W-1:0]   r_sym_idx;
  logic [SYM_CNT_W-1:0]   r_step_cnt;
  logic                   r_frame_start;
  logic                   r_frame_end;
  logic                   r_odd_drop;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_xfer;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (flush)         w_state_nxt = EMPTY;
    else if (w_accept) w_state_nxt = (r_state == EMPTY) ? HALF : EMPTY;
  end

  // A second bit may only land if the output register is free or drains this cycle.
  always_comb begin
    w_in_ready = !flush && (r_state == EMPTY || !r_pair_valid || pair_ready);
    w_accept   = in_valid && w_in_ready;
    w_load     = w_accept && (r_state == HALF);
    w_xfer     = r_pair_valid && pair_ready && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_bit    <= 1'b0;
      r_rx_pair     <= 2'b00;
      r_pair_valid  <= 1'b0;
      r_sym_idx     <= '0;
      r_step_cnt    <= '0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_odd_drop    <= 1'b0;
    end else begin
      r_odd_drop <= flush && (r_state == HALF);
      if (w_accept && r_state == EMPTY) r_hold_bit <= in_bit;
      if (flush) begin
        r_pair_valid <= 1'b0;
        r_step_cnt   <= '0;
      end else if (w_load) begin
        r_rx_pair     <= {r_hold_bit, in_bit};
        r_pair_valid  <= 1'b1;
        r_sym_idx     <= r_step_cnt;
        r_frame_start <= (r_step_cnt == '0);
        r_frame_end   <= (r_step_cnt == LAST_IDX);
        r_step_cnt    <= (r_step_cnt == LAST_IDX) ? '0 : r_step_cnt + 1'b1;
      end else if (w_xfer) begin
        r_pair_valid <= 1'b0;
      end
    end
  end

`ifdef RX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Survives flush on purpose; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_frame_cnt <= 16'd0;
    else if (w_xfer && r_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

  // A flush hides a pending pair from downstream in the same cycle.
  assign in_ready    = w_in_ready;
  assign pair_valid  = r_pair_valid && !flush;
  assign rx_pair     = r_rx_pair;
  assign sym_idx     = r_sym_idx;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign odd_drop    = r_odd_drop;

endmodule

// File: tb/tb_rx_pair_framer.sv
// Scoreboard bench for rx_pair_framer (FRAME_LEN=4): expected pairs are queued on load and popped on transfer.
// Build with RX_FRAME_CNT_EN defined to also check the frame counter.
module tb_rx_pair_framer;

  localparam int FRAME_LEN = 4;
  localparam int SYM_CNT_W = 8;

  typedef struct packed {
    logic [1:0]           pair;
    logic [SYM_CNT_W-1:0] idx;
    logic                 fs;
    logic                 fe;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_bit = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 flush = 1'b0;
  logic [1:0]           rx_pair;
  logic                 pair_valid;
  logic                 pair_ready = 1'b0;
  logic [SYM_CNT_W-1:0] sym_idx;
  logic                 frame_start;
  logic                 frame_end;
  logic                 odd_drop;
`ifdef RX_FRAME_CNT_EN
  logic [15:0]          frame_cnt;
`endif

  rx_pair_framer #(.FRAME_LEN(FRAME_LEN), .SYM_CNT_W(SYM_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .rx_pair(rx_pair), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .sym_idx(sym_idx), .frame_start(frame_start), .frame_end(frame_end),
`ifdef RX_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .odd_drop(odd_drop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        q[$];
  logic        m_half = 1'b0;
  logic        m_hold = 1'b0;
  int          m_cnt = 0;
  logic        m_odd = 1'b0;
  logic [15:0] m_fcnt = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_half = 1'b0;
    m_hold = 1'b0;
    m_cnt  = 0;
    m_odd  = 1'b0;
    m_fcnt = 16'd0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rx_pair"}, 32'(rx_pair), 32'd0);
    check({tag, "_pair_valid"}, 32'(pair_valid), 32'd0);
    check({tag, "_sym_idx"}, 32'(sym_idx), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
    check({tag, "_odd_drop"}, 32'(odd_drop), 32'd0);
`ifdef RX_FRAME_CNT_EN
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`endif
  endtask

  // One clock cycle: drive, check against the model, advance the model, clock.
  task automatic cycle(input logic b, input logic v, input logic r, input logic f);
    logic exp_valid;
    logic exp_rdy;
    exp_t e;
    in_bit = b; in_valid = v; pair_ready = r; flush = f;
    #1;
    exp_valid = (q.size() != 0) && !f;
    exp_rdy   = !f && (!m_half || q.size() == 0 || r);
    check("pair_valid", 32'(pair_valid), 32'(exp_valid));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("odd_drop", 32'(odd_drop), 32'(m_odd));
`ifdef RX_FRAME_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
    if (exp_valid) begin
      e = q[0];
      check("rx_pair", 32'(rx_pair), 32'(e.pair));
      check("sym_idx", 32'(sym_idx), 32'(e.idx));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("frame_end", 32'(frame_end), 32'(e.fe));
      if (r) begin
        void'(q.pop_front());
        if (e.fe) m_fcnt = m_fcnt + 16'd1;
      end
    end
    m_odd = f && m_half;
    if (f) begin
      m_half = 1'b0;
      m_cnt  = 0;
      q.delete();
    end else if (v && exp_rdy) begin
      if (!m_half) begin
        m_hold = b;
        m_half = 1'b1;
      end else begin
        e.pair = {m_hold, b};
        e.idx  = SYM_CNT_W'(m_cnt);
        e.fs   = (m_cnt == 0);
        e.fe   = (m_cnt == FRAME_LEN - 1);
        q.push_back(e);
        m_cnt  = (m_cnt + 1) % FRAME_LEN;
        m_half = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic r);
    cycle(b, 1'b1, r, 1'b0);
  endtask

  initial begin
    exp_t first;
    logic [1:0] held_pair;
    // Reset state
    rst_n = 1'b0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Bits 1,0,1,1 -> pairs 10 then 11, idx 0 then 1
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("first_pair_queued", 32'(q.size()), 32'd1);
    first = q[0];
    check("first_pair_valid_now", 32'(pair_valid), 32'd1);
    check("first_pair_value", 32'(rx_pair), 32'(2'b10));
    check("first_pair_start", 32'(frame_start), 32'd1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    check("second_pair_value", 32'(rx_pair), 32'(2'b11));
    check("second_pair_idx", 32'(sym_idx), 32'd1);
    check("second_pair_start", 32'(frame_start), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Resync, then 10 pairs streamed continuously
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("stream_idx_after_10", 32'(m_cnt), 32'd2);

    // Backpressure: pending pair, ready low for 5 cycles
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    held_pair = rx_pair;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 1'b0);
      check("stall_stable", 32'(rx_pair), 32'(held_pair));
    end
    check("stall_half_held", 32'(m_half), 32'd1);
    send_bit(1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Flush while holding one bit
    send_bit(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    check("post_flush_pair", 32'(rx_pair), 32'(2'b01));
    check("post_flush_idx", 32'(sym_idx), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with pending pair and ready high
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_discard", 32'(pair_valid), 32'd0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("flush_restart_idx", 32'(sym_idx), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Three full frames, then random traffic with occasional flushes
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2 * 3 * FRAME_LEN; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));

    // Reset pulse mid-frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #2;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("after_reset_idx", 32'(sym_idx), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("first_pair_idx", 32'(first.idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
